serdes_link_bist: RTL
=====================

SERDES_LINK_BIST -- requirements
Module: serdes_link_bist

Interface
REQ-001 Parameter DATA_W, default 4: bits per beat on the TX and RX paths (4..32).
REQ-002 Parameter ERR_CNT_W, default 16: width of the saturating bit-error counter.
REQ-003 Parameter LOCK_THRESH, default 16: consecutive error-free RX beats required to declare lock.
REQ-004 Parameter LOSS_THRESH, default 4: consecutive errored RX beats that drop lock.
REQ-005 clk  in  1  single block clock; all logic is in this domain.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 en  in  1  BIST enable; low holds generator and checker in IDLE.
REQ-008 mode  in  3  pattern select: 0 = PRBS7, 1 = PRBS15, 2 = PRBS31, 3 = alternating 1010…, 4..7 reserved (treated as 0).
REQ-009 clear  in  1  one-cycle pulse that zeroes err_cnt and prbs_err.
REQ-010 inject_err  in  1  pulse that inverts bit 0 of the next transmitted beat.
REQ-011 tx_ready  in  1  downstream serializer accepts a beat.
REQ-012 tx_data  out  DATA_W  generated beat; the earliest sequence bit is in bit DATA_W-1.
REQ-013 tx_valid  out  1  tx_data is valid.
REQ-014 rx_data  in  DATA_W  received beat, same bit order as tx_data.
REQ-015 rx_valid  in  1  rx_data is valid this cycle.
REQ-016 locked  out  1  checker is in LOCKED.
REQ-017 prbs_err  out  1  sticky flag: at least one bit error counted since the last clear.
REQ-018 err_cnt  out  ERR_CNT_W  saturating count of errored bits.

Function
REQ-019 Polynomials: PRBS7 is x^7+x^6+1, PRBS15 is x^15+x^14+1, PRBS31 is x^31+x^28+1; all are Fibonacci LFSRs seeded with all ones.
REQ-020 The generator advances DATA_W sequence bits per accepted beat (tx_valid && tx_ready) and holds tx_data stable while tx_ready is low.
REQ-021 tx_valid is high whenever en=1, and goes high the first cycle after en rises.
REQ-022 When en falls, tx_valid drops the next cycle and the generator reseeds to all ones.
REQ-023 inject_err is latched until the next accepted beat and affects exactly one beat; the LFSR state itself is not corrupted.
REQ-024 Checker states and transitions:
- IDLE: the state whenever en=0.
- SEED: ceil(N/DATA_W) valid beats are shifted into the checker LFSR (N = polynomial order; 1 beat in alternating mode).
- CHECK: each valid beat is compared with the prediction; an error returns to SEED; LOCK_THRESH consecutive clean beats go to LOCKED.
- LOCKED: LOSS_THRESH consecutive errored beats go to SEED.
REQ-025 Errors are counted only in LOCKED: err_cnt += popcount(rx_data ^ predicted), saturating at all ones; prbs_err is set on any nonzero count.
REQ-026 A change of mode while en=1 reseeds the generator and sends the checker to SEED within one cycle; err_cnt is retained.
REQ-027 clear has priority over a simultaneous increment: the result is err_cnt=0 and prbs_err=0.
REQ-028 Beats with rx_valid=0 are ignored and do not break the consecutive-beat counts.
REQ-029 Outputs are registered; latency from the last qualifying rx beat to the locked or err_cnt update is 1 cycle.

Reset
REQ-030 During rst_n=0: tx_valid=0, tx_data=0, locked=0, prbs_err=0, err_cnt=0, checker in IDLE, LFSRs all ones, inject latch cleared.
REQ-031 Reset release is synchronised internally, taking effect on the second clk edge after rst_n rises.

Structure
REQ-032 A shared package holds the mode encodings, the tap constants for the three polynomials, and the checker-state enum.
REQ-033 A sub-module prbs_lfsr_step (parametrised by DATA_W, combinational, mode-selected) computes the next state and beat; generator and checker each instantiate one.

Verification
REQ-034 Loopback with tx_ready=1, DATA_W=4, PRBS7, LOCK_THRESH=16 -> locked rises 1 cycle after the 18th rx beat (2 seed + 16 check); err_cnt stays 0 over 10,000 beats.
REQ-035 While locked, pulse inject_err once -> err_cnt=1, prbs_err=1, locked stays 1.
REQ-036 ERR_CNT_W=4, flip bits 0 and 1 on 10 isolated beats -> err_cnt saturates at 15, locked stays 1.
REQ-037 While locked, invert all rx bits for 4 beats -> locked=0 after the 4th; the checker relocks after 18 clean beats.
REQ-038 Change mode 0->1 mid-run, then pulse clear together with an error -> relock takes 4+16 beats on PRBS15, and err_cnt=0 after the clear.
REQ-039 Assert rst_n=0 mid-run with tx_ready toggling randomly -> all REQ-030 values hold immediately; lock is reacquired in 18 beats after release.

Source files
------------

// File: rtl/serdes_link_bist_pkg.sv
// Purpose: shared definitions for the SERDES link BIST (pattern modes, LFSR taps, checker states).
// Latency: n/a (types, constants and pure helper functions only).
// Backpressure: n/a.
package serdes_link_bist_pkg;

  // One state register wide enough for the longest polynomial; shorter ones use the low bits.
  localparam int LFSR_W = 31;

  typedef enum logic [1:0] {
    MODE_PRBS7  = 2'd0,
    MODE_PRBS15 = 2'd1,
    MODE_PRBS31 = 2'd2,
    MODE_ALT    = 2'd3
  } mode_t;

  // Taps given as polynomial exponents. With s[0] holding the newest sequence bit,
  // the Fibonacci feedback is s[TAP_A-1] ^ s[TAP_B-1].
  localparam int PRBS7_TAP_A  = 7;
  localparam int PRBS7_TAP_B  = 6;
  localparam int PRBS15_TAP_A = 15;
  localparam int PRBS15_TAP_B = 14;
  localparam int PRBS31_TAP_A = 31;
  localparam int PRBS31_TAP_B = 28;

  typedef enum logic [1:0] {
    CHK_IDLE   = 2'd0,
    CHK_SEED   = 2'd1,
    CHK_CHECK  = 2'd2,
    CHK_LOCKED = 2'd3
  } chk_state_t;

  // Reserved encodings 4..7 fall back to PRBS7.
  function automatic mode_t decode_mode(input logic [2:0] raw);
    if (raw[2]) return MODE_PRBS7;
    return mode_t'(raw[1:0]);
  endfunction

  // Beats needed to fill the checker LFSR from received data: ceil(order / data_w).
  function automatic int seed_beats(input mode_t m, input int data_w);
    case (m)
      MODE_PRBS7:  return (PRBS7_TAP_A + data_w - 1) / data_w;
      MODE_PRBS15: return (PRBS15_TAP_A + data_w - 1) / data_w;
      MODE_PRBS31: return (PRBS31_TAP_A + data_w - 1) / data_w;
      default:     return 1;
    endcase
  endfunction

endpackage

// File: rtl/serdes_link_bist_prbs_lfsr_step.sv
// Purpose: advance a mode-selected Fibonacci LFSR by DATA_W bits, or shift DATA_W received bits in.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to register next_state.
// Ports: mode (pattern), state (current LFSR), load_en/load_data (shift data in instead of feedback),
//        next_state (LFSR after DATA_W bits), beat (the DATA_W bits, earliest in bit DATA_W-1).
module prbs_lfsr_step
  import serdes_link_bist_pkg::*;
#(
  parameter int DATA_W = 4
) (
  input  mode_t              mode,
  input  logic [LFSR_W-1:0]  state,
  input  logic               load_en,
  input  logic [DATA_W-1:0]  load_data,
  output logic [LFSR_W-1:0]  next_state,
  output logic [DATA_W-1:0]  beat
);

  logic [LFSR_W-1:0] s;
  logic              fb;
  logic              b;

  always_comb begin
    s    = state;
    beat = '0;
    fb   = 1'b0;
    b    = 1'b0;
    for (int i = 0; i < DATA_W; i++) begin
      case (mode)
        MODE_PRBS7:  fb = s[PRBS7_TAP_A-1]  ^ s[PRBS7_TAP_B-1];
        MODE_PRBS15: fb = s[PRBS15_TAP_A-1] ^ s[PRBS15_TAP_B-1];
        MODE_PRBS31: fb = s[PRBS31_TAP_A-1] ^ s[PRBS31_TAP_B-1];
        // Alternating pattern: each bit is the complement of the previous one.
        default:     fb = ~s[0];
      endcase
      // In load mode the received bit replaces the feedback, so after enough
      // bits the register holds exactly the transmitter's state.
      b = load_en ? load_data[DATA_W-1-i] : fb;
      beat[DATA_W-1-i] = b;
      s = {s[LFSR_W-2:0], b};
    end
    next_state = s;
  end

endmodule

// File: rtl/serdes_link_bist.sv
// Purpose: PRBS/alternating pattern generator and self-synchronising lock/error checker for a SERDES link.
// Latency: tx beat registered (first beat the cycle after en); locked/err_cnt update 1 cycle after an rx beat.
// Backpressure: tx_data/tx_valid held while tx_ready is low; rx beats with rx_valid=0 are ignored.
// Ports: clk, rst_n (async active-low, release synchronised), en, mode[2:0], clear, inject_err,
//        tx_ready -> tx_data/tx_valid; rx_data/rx_valid -> locked, prbs_err, err_cnt.
module serdes_link_bist
  import serdes_link_bist_pkg::*;
#(
  parameter int DATA_W      = 4,
  parameter int ERR_CNT_W   = 16,
  parameter int LOCK_THRESH = 16,
  parameter int LOSS_THRESH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic [2:0]           mode,
  input  logic                 clear,
  input  logic                 inject_err,
  input  logic                 tx_ready,
  output logic [DATA_W-1:0]    tx_data,
  output logic                 tx_valid,
  input  logic [DATA_W-1:0]    rx_data,
  input  logic                 rx_valid,
  output logic                 locked,
  output logic                 prbs_err,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  localparam int RUN_MAX = (LOCK_THRESH > LOSS_THRESH) ? LOCK_THRESH : LOSS_THRESH;
  localparam int RUN_W   = $clog2(RUN_MAX + 1);
  localparam int POP_W   = $clog2(DATA_W + 1);
  localparam int SUM_W   = ERR_CNT_W + POP_W;
  localparam logic [ERR_CNT_W-1:0] CNT_MAX = '1;

  // ---------------------------------------------------------------------------
  // Reset: asserts asynchronously, releases after two clk edges.
  // ---------------------------------------------------------------------------
  logic [1:0] rst_sync;
  logic       rst_int_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync <= 2'b00;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end

  assign rst_int_n = rst_sync[1];

  // ---------------------------------------------------------------------------
  // Mode tracking: a change while running restarts both ends of the link.
  // ---------------------------------------------------------------------------
  mode_t mode_eff;
  mode_t mode_q;
  logic  mode_chg;

  assign mode_eff = decode_mode(mode);
  assign mode_chg = (mode_eff != mode_q);

  // ---------------------------------------------------------------------------
  // Generator
  // ---------------------------------------------------------------------------
  logic [LFSR_W-1:0] gen_state;
  logic [LFSR_W-1:0] gen_src;
  logic [LFSR_W-1:0] gen_next;
  logic [DATA_W-1:0] gen_beat;
  logic              gen_load;
  logic              inj_pend;
  logic              inj_now;

  // gen_state is already all ones whenever tx_valid is low, so only a mode change needs a forced reseed.
  assign gen_src  = mode_chg ? '1 : gen_state;
  assign gen_load = !tx_valid || mode_chg || tx_ready;
  assign inj_now  = inj_pend || inject_err;

  prbs_lfsr_step #(.DATA_W(DATA_W)) u_gen_step (
    .mode       (mode_eff),
    .state      (gen_src),
    .load_en    (1'b0),
    .load_data  ('0),
    .next_state (gen_next),
    .beat       (gen_beat)
  );

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      tx_valid  <= 1'b0;
      tx_data   <= '0;
      gen_state <= '1;
      inj_pend  <= 1'b0;
      mode_q    <= MODE_PRBS7;
    end else begin
      mode_q <= mode_eff;
      if (!en) begin
        tx_valid  <= 1'b0;
        tx_data   <= '0;
        gen_state <= '1;
        if (inject_err) inj_pend <= 1'b1;
      end else if (gen_load) begin
        // The injected flip rides on the registered beat only; gen_state stays clean.
        tx_valid  <= 1'b1;
        tx_data   <= gen_beat ^ {{(DATA_W-1){1'b0}}, inj_now};
        gen_state <= gen_next;
        inj_pend  <= 1'b0;
      end else if (inject_err) begin
        inj_pend <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Checker
  // ---------------------------------------------------------------------------
  chk_state_t        chk_state;
  chk_state_t        chk_nxt;
  logic [LFSR_W-1:0] chk_lfsr;
  logic [LFSR_W-1:0] chk_next;
  logic [DATA_W-1:0] chk_pred;
  logic [DATA_W-1:0] err_bits;
  logic              beat_err;
  logic [POP_W-1:0]  pop;
  logic [5:0]        seed_need;
  logic [5:0]        seed_cnt;
  logic [5:0]        seed_cnt_nxt;
  logic [RUN_W-1:0]  run_cnt;
  logic [RUN_W-1:0]  run_cnt_nxt;
  logic [LFSR_W-1:0] lfsr_nxt;
  logic              add_en;
  logic              rx_take;
  logic [SUM_W-1:0]  err_sum;

  prbs_lfsr_step #(.DATA_W(DATA_W)) u_chk_step (
    .mode       (mode_eff),
    .state      (chk_lfsr),
    .load_en    (chk_state == CHK_SEED),
    .load_data  (rx_data),
    .next_state (chk_next),
    .beat       (chk_pred)
  );

  assign err_bits  = rx_data ^ chk_pred;
  assign beat_err  = |err_bits;
  assign seed_need = 6'(seed_beats(mode_eff, DATA_W));
  // The beat arriving in the cycle of a mode change belongs to the old pattern and is dropped.
  assign rx_take   = en && !mode_chg && rx_valid;

  always_comb begin
    pop = '0;
    for (int i = 0; i < DATA_W; i++) pop = pop + POP_W'(err_bits[i]);
  end

  // State register
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) chk_state <= CHK_IDLE;
    else            chk_state <= chk_nxt;
  end

  // Next-state logic
  always_comb begin
    chk_nxt = chk_state;
    if (!en) begin
      chk_nxt = CHK_IDLE;
    end else if (mode_chg) begin
      chk_nxt = CHK_SEED;
    end else begin
      case (chk_state)
        CHK_IDLE:  chk_nxt = CHK_SEED;
        CHK_SEED:  if (rx_valid && (seed_cnt == seed_need - 6'd1)) chk_nxt = CHK_CHECK;
        CHK_CHECK: begin
          if (rx_valid) begin
            if (beat_err)                                  chk_nxt = CHK_SEED;
            else if (run_cnt == RUN_W'(LOCK_THRESH - 1))   chk_nxt = CHK_LOCKED;
          end
        end
        CHK_LOCKED: if (rx_valid && beat_err && (run_cnt == RUN_W'(LOSS_THRESH - 1))) chk_nxt = CHK_SEED;
        default:   chk_nxt = CHK_IDLE;
      endcase
    end
  end

  // Output / datapath control
  always_comb begin
    seed_cnt_nxt = seed_cnt;
    run_cnt_nxt  = run_cnt;
    lfsr_nxt     = chk_lfsr;
    add_en       = 1'b0;
    if (rx_take) begin
      case (chk_state)
        CHK_SEED: begin
          lfsr_nxt     = chk_next;
          seed_cnt_nxt = seed_cnt + 6'd1;
        end
        CHK_CHECK: begin
          lfsr_nxt    = chk_next;
          run_cnt_nxt = beat_err ? '0 : run_cnt + RUN_W'(1);
        end
        CHK_LOCKED: begin
          // Keep free-running on the prediction so errored beats do not derail it.
          lfsr_nxt    = chk_next;
          add_en      = 1'b1;
          run_cnt_nxt = beat_err ? run_cnt + RUN_W'(1) : '0;
        end
        default: ;
      endcase
    end
    if ((chk_nxt != chk_state) || mode_chg) begin
      seed_cnt_nxt = '0;
      run_cnt_nxt  = '0;
    end
    if (chk_nxt == CHK_IDLE) lfsr_nxt = '1;
  end

  assign err_sum = SUM_W'(err_cnt) + SUM_W'(pop);

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      chk_lfsr <= '1;
      seed_cnt <= '0;
      run_cnt  <= '0;
      locked   <= 1'b0;
      err_cnt  <= '0;
      prbs_err <= 1'b0;
    end else begin
      chk_lfsr <= lfsr_nxt;
      seed_cnt <= seed_cnt_nxt;
      run_cnt  <= run_cnt_nxt;
      locked   <= (chk_nxt == CHK_LOCKED);
      if (clear) begin
        err_cnt  <= '0;
        prbs_err <= 1'b0;
      end else if (add_en && (pop != '0)) begin
        err_cnt  <= (err_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : err_sum[ERR_CNT_W-1:0];
        prbs_err <= 1'b1;
      end
    end
  end

endmodule
